// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus target and its synchronisers.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_HOLD,
    ST_WATCH,
    ST_IGNORE,
    ST_BERRH
  } state_e;

  localparam logic [2:0]  FC_INTACK      = 3'b111;
  localparam int unsigned SYNC_DEPTH     = 2;
  localparam int unsigned CLK_SYNC_DEPTH = 3;

endpackage

// File: rtl/m68k_edge_sync.sv
// Multi-flop synchroniser for a vector of asynchronous signals, with
// rise/fall pulses derived from the two oldest stages.
module m68k_edge_sync #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];

  always_comb begin
    s_d[0] = async_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      s_d[i] = s_q[i-1];
    end
  end

  // Stages reset low so an active-low strobe held asserted through reset
  // is never mistaken for an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '{default: '0};
    end else begin
      s_q <= s_d;
    end
  end

  assign sync_o = s_q[DEPTH-1];
  assign rise_o = ~s_q[DEPTH-1] &  s_q[DEPTH-2];
  assign fall_o =  s_q[DEPTH-1] & ~s_q[DEPTH-2];

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 bus responder: register-file target inside an address window and
// bus-error watchdog for unanswered cycles outside it.
module m68k_bus_target
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'hDE0000,
  parameter logic [23:0] ADDR_MASK   = 24'hFFFFE0,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        PI_CLK,
  input  logic        RESET_n,
  input  logic        M68K_CLK,
  input  logic [23:1] M68K_A,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  input  logic        M68K_DTACK_n_IN,
  input  logic        M68K_VPA_n_IN,
  output logic        DTACK_DRV,
  output logic        BERR_DRV,
  output logic [15:0] HIT_COUNT,
  output logic [7:0]  BERR_COUNT
);

  logic [5:0] strb_s, strb_rise, strb_fall;
  logic       c7m_s, c7m_rise, c7m_fall;
  logic       as_s, uds_s, lds_s, rw_s, dtack_s, vpa_s;

  m68k_edge_sync #(.WIDTH(6), .DEPTH(SYNC_DEPTH)) u_strb_sync (
    .clk    (PI_CLK),
    .rst_n  (RESET_n),
    .async_i({M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW,
              M68K_DTACK_n_IN, M68K_VPA_n_IN}),
    .sync_o (strb_s),
    .rise_o (strb_rise),
    .fall_o (strb_fall)
  );

  m68k_edge_sync #(.WIDTH(1), .DEPTH(CLK_SYNC_DEPTH)) u_clk_sync (
    .clk    (PI_CLK),
    .rst_n  (RESET_n),
    .async_i(M68K_CLK),
    .sync_o (c7m_s),
    .rise_o (c7m_rise),
    .fall_o (c7m_fall)
  );

  assign {as_s, uds_s, lds_s, rw_s, dtack_s, vpa_s} = strb_s;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                rw_q, rw_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic [7:0]          tcnt_q, tcnt_d;
  logic [15:0]         dout_q, dout_d;
  logic                doe_q, doe_d;
  logic                dtack_q, dtack_d;
  logic                berr_q, berr_d;
  logic [15:0]         hits_q, hits_d;
  logic [7:0]          berrs_q, berrs_d;
  logic [15:0]         mem_q [2**ADDR_W];
  logic [15:0]         mem_d [2**ADDR_W];

  logic [23:0] byte_addr;
  logic        hit;

  assign byte_addr = {M68K_A, 1'b0};
  assign hit       = (byte_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    dtack_d = dtack_q;
    berr_d  = berr_q;
    hits_d  = hits_q;
    berrs_d = berrs_q;
    mem_d   = mem_q;

    unique case (state_q)
      ST_ARM: if (as_s) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!as_s) begin
          idx_d = M68K_A[ADDR_W:1];
          rw_d  = rw_s;
          if (hit && M68K_FC != FC_INTACK) begin
            state_d = ST_WAIT;
            wcnt_d  = 8'(WAIT_STATES);
          end else begin
            state_d = ST_WATCH;
            tcnt_d  = '0;
          end
        end
      end
      ST_WAIT: begin
        if (c7m_fall && wcnt_q != '0) wcnt_d = wcnt_q - 8'd1;
        // An aborted cycle (AS released before we answered) is dropped.
        if (as_s) state_d = ST_IDLE;
        else if (wcnt_q == '0 && (rw_q || !uds_s || !lds_s)) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (rw_q) begin
          dout_d = mem_q[idx_q];
          doe_d  = 1'b1;
        end else begin
          if (!uds_s) mem_d[idx_q][15:8] = M68K_D_IN[15:8];
          if (!lds_s) mem_d[idx_q][7:0]  = M68K_D_IN[7:0];
        end
        dtack_d = 1'b1;
        hits_d  = hits_q + 16'd1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (as_s) begin
          dtack_d = 1'b0;
          doe_d   = 1'b0;
          dout_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_WATCH: begin
        if (c7m_fall) tcnt_d = tcnt_q + 8'd1;
        // A foreign responder wins over a timeout landing in the same cycle.
        if (!dtack_s || !vpa_s) begin
          state_d = ST_IGNORE;
        end else if (as_s) begin
          state_d = ST_IDLE;
        end else if (tcnt_d == 8'(TIMEOUT)) begin
          berr_d  = 1'b1;
          berrs_d = berrs_q + 8'd1;
          state_d = ST_BERRH;
        end
      end
      ST_IGNORE: if (as_s) state_d = ST_IDLE;
      ST_BERRH: begin
        if (as_s) begin
          berr_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ST_ARM;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
      dtack_q <= 1'b0;
      berr_q  <= 1'b0;
      hits_q  <= '0;
      berrs_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
      hits_q  <= hits_d;
      berrs_q <= berrs_d;
      mem_q   <= mem_d;
    end
  end

  assign M68K_D_OUT = dout_q;
  assign M68K_D_OE  = doe_q;
  assign DTACK_DRV  = dtack_q;
  assign BERR_DRV   = berr_q;
  assign HIT_COUNT  = hits_q;
  assign BERR_COUNT = berrs_q;

endmodule
